pipe_hazard_ctrl: RTL and testbench

Pipeline controller for the 5-stage MIPS datapath. Generates every per-stage stall/clear strobe and the PC hold/redirect controls from the load-use, branch/jump and memory-wait conditions. Also sequences the post-reset pipeline flush and a bounded data-memory wait with timeout. Sits beside the datapath; all outputs are consumed in the same cycle by the datapath pipe registers.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_if.sv | 45 ++++
 rtl/pipe_hazard_ctrl_perf_counters.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and limits for the MIPS pipeline hazard controller.
package MIPS_DEF;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StMemWait
    } hz_state_t;

    localparam int unsigned HZ_INIT_CYCLES_MAX = 15;
    localparam int unsigned HZ_TIMEOUT_MAX     = 255;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: datapath conditions in, stage strobes and perf counters out.
interface pipe_hazard_ctrl_if;

    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  ex_wr_addr;
    logic        ex_mem_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ack;

    logic        pc_stall;
    logic        pc_redirect;
    logic        if_stall;
    logic        if_clear;
    logic        id_stall;
    logic        id_clear;
    logic        ex_stall;
    logic        ex_clear;
    logic        mem_stall;
    logic        mem_clear;
    logic        mem_abort;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] bubble_cnt;

    // Datapath side
    modport master (
        output id_rs_addr, id_rt_addr, id_use_rs, id_use_rt, ex_wr_addr, ex_mem_rd,
               ex_redirect, mem_req, mem_ack,
        input  pc_stall, pc_redirect, if_stall, if_clear, id_stall, id_clear, ex_stall,
               ex_clear, mem_stall, mem_clear, mem_abort, stall_cnt, flush_cnt, bubble_cnt
    );

    // Controller side
    modport slave (
        input  id_rs_addr, id_rt_addr, id_use_rs, id_use_rt, ex_wr_addr, ex_mem_rd,
               ex_redirect, mem_req, mem_ack,
        output pc_stall, pc_redirect, if_stall, if_clear, id_stall, id_clear, ex_stall,
               ex_clear, mem_stall, mem_clear, mem_abort, stall_cnt, flush_cnt, bubble_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_perf_counters.sv
// Stall / flush / bubble performance counters; built only when HAZARD_PERF_EN is defined.
module hz_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_inc_i,
    input  logic        flush_inc_i,
    input  logic        bubble_inc_i,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o,
    output logic [31:0] bubble_cnt_o
);

    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;
    logic [31:0] bubble_q, bubble_d;

    always_comb begin
        stall_d  = stall_q + {31'd0, stall_inc_i};
        flush_d  = flush_q + {31'd0, flush_inc_i};
        bubble_d = bubble_q + {31'd0, bubble_inc_i};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q  <= '0;
            flush_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            bubble_q <= bubble_d;
        end
    end

    assign stall_cnt_o  = stall_q;
    assign flush_cnt_o  = flush_q;
    assign bubble_cnt_o = bubble_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage MIPS pipeline stall/clear/redirect controller with post-reset flush and bounded
// memory wait. Define HAZARD_PERF_EN to build the performance counters.
module pipe_hazard_ctrl
    import MIPS_DEF::*;
#(
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [3:0] InitLoad   = 4'(INIT_CYCLES - 1);
    localparam logic [7:0] TimeoutVal = 8'(MEM_TIMEOUT);

    hz_state_t  state_q, state_d;
    logic [3:0] init_cnt_q, init_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    logic pc_stall, pc_redirect, if_stall, if_clear, id_stall, id_clear;
    logic ex_stall, ex_clear, mem_clear, abort;
    logic load_use, mem_wait;
    logic flush_inc, bubble_inc, stall_inc;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign load_use = hz.ex_mem_rd && (hz.ex_wr_addr != 5'd0) &&
                      ((hz.id_use_rs && (hz.id_rs_addr == hz.ex_wr_addr)) ||
                       (hz.id_use_rt && (hz.id_rt_addr == hz.ex_wr_addr)));
    assign mem_wait = hz.mem_req && !hz.mem_ack;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        pc_stall    = 1'b0;
        pc_redirect = 1'b0;
        if_stall    = 1'b0;
        if_clear    = 1'b0;
        id_stall    = 1'b0;
        id_clear    = 1'b0;
        ex_stall    = 1'b0;
        ex_clear    = 1'b0;
        mem_clear   = 1'b0;
        abort       = 1'b0;
        flush_inc   = 1'b0;
        bubble_inc  = 1'b0;

        unique case (state_q)
            StInit: begin
                pc_stall  = 1'b1;
                if_clear  = 1'b1;
                id_clear  = 1'b1;
                ex_clear  = 1'b1;
                mem_clear = 1'b1;
                if (init_cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    init_cnt_d = init_cnt_q - 4'd1;
                end
            end
            StRun: begin
                if (mem_wait) begin
                    {pc_stall, if_stall, id_stall, ex_stall, mem_clear} = '1;
                    state_d    = StMemWait;
                    wait_cnt_d = 8'd1;
                end else if (hz.ex_redirect) begin
                    pc_redirect = 1'b1;
                    if_clear    = 1'b1;
                    id_clear    = 1'b1;
                    flush_inc   = 1'b1;
                end else if (load_use) begin
                    pc_stall   = 1'b1;
                    if_stall   = 1'b1;
                    id_clear   = 1'b1;
                    bubble_inc = 1'b1;
                end
            end
            StMemWait: begin
                // A dropped request counts as completion.
                if (!mem_wait) begin
                    {pc_stall, if_stall, id_stall, ex_stall, mem_clear} = '1;
                    state_d = StRun;
                end else if (wait_cnt_q == TimeoutVal) begin
                    mem_clear = 1'b1;
                    abort     = 1'b1;
                    state_d   = StRun;
                end else begin
                    {pc_stall, if_stall, id_stall, ex_stall, mem_clear} = '1;
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign stall_inc = pc_stall && (state_q != StInit);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StInit;
            init_cnt_q <= InitLoad;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign hz.pc_stall    = pc_stall;
    assign hz.pc_redirect = pc_redirect;
    assign hz.if_stall    = if_stall;
    assign hz.if_clear    = if_clear;
    assign hz.id_stall    = id_stall;
    assign hz.id_clear    = id_clear;
    assign hz.ex_stall    = ex_stall;
    assign hz.ex_clear    = ex_clear;
    assign hz.mem_stall   = 1'b0;
    assign hz.mem_clear   = mem_clear;
    // Abort is suppressed while reset is held so a reset mid-wait never fires it.
    assign hz.mem_abort   = abort && rst_n;

`ifdef HAZARD_PERF_EN
    hz_perf_counters u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_inc_i  (stall_inc),
        .flush_inc_i  (flush_inc),
        .bubble_inc_i (bubble_inc),
        .stall_cnt_o  (hz.stall_cnt),
        .flush_cnt_o  (hz.flush_cnt),
        .bubble_cnt_o (hz.bubble_cnt)
    );
`else
    logic unused_perf;
    assign unused_perf   = ^{stall_inc, flush_inc, bubble_inc};
    assign hz.stall_cnt  = '0;
    assign hz.flush_cnt  = '0;
    assign hz.bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized scoreboard bench for pipe_hazard_ctrl against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned INIT_CYCLES = 4;
    localparam int unsigned MEM_TIMEOUT = 16;

    // Strobe vector order:
    // pc_stall pc_redirect if_stall if_clear id_stall id_clear ex_stall ex_clear
    // mem_stall mem_clear mem_abort
    localparam logic [10:0] S_NONE  = 11'b0_0_0_0_0_0_0_0_0_0_0;
    localparam logic [10:0] S_INIT  = 11'b1_0_0_1_0_1_0_1_0_1_0;
    localparam logic [10:0] S_WAIT  = 11'b1_0_1_0_1_0_1_0_0_1_0;
    localparam logic [10:0] S_REDIR = 11'b0_1_0_1_0_1_0_0_0_0_0;
    localparam logic [10:0] S_LU    = 11'b1_0_1_0_0_1_0_0_0_0_0;
    localparam logic [10:0] S_ABORT = 11'b0_0_0_0_0_0_0_0_0_1_1;

    typedef struct {
        logic        rst_cyc;
        logic [10:0] strb;
        logic [95:0] cnts;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(
        .INIT_CYCLES (INIT_CYCLES),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model: flush cycles still owed, and how deep into a memory wait we are.
    int          init_left = 0;
    int          waited    = 0;
    int unsigned m_sc = 0, m_fc = 0, m_bc = 0;

    task automatic step(input logic rs_n, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] wr,
                        input logic mrd, input logic redir, input logic req,
                        input logic ack);
        exp_t e;
        logic lu;
        @(posedge clk);
        #1;
        rst_n          = rs_n;
        hz.id_rs_addr  = rs;
        hz.id_rt_addr  = rt;
        hz.id_use_rs   = urs;
        hz.id_use_rt   = urt;
        hz.ex_wr_addr  = wr;
        hz.ex_mem_rd   = mrd;
        hz.ex_redirect = redir;
        hz.mem_req     = req;
        hz.mem_ack     = ack;

        e.rst_cyc = !rs_n;
        e.strb    = S_NONE;
`ifdef HAZARD_PERF_EN
        e.cnts = {m_sc, m_fc, m_bc};
`else
        e.cnts = '0;
`endif
        lu = mrd && (wr != 0) && ((urs && rs == wr) || (urt && rt == wr));
        if (!rs_n) begin
            init_left = INIT_CYCLES;
            waited    = 0;
            m_sc = 0; m_fc = 0; m_bc = 0;
        end else if (init_left > 0) begin
            e.strb    = S_INIT;
            init_left = init_left - 1;
        end else if (waited > 0) begin
            if (ack || !req) begin
                e.strb = S_WAIT; m_sc++; waited = 0;
            end else if (waited == MEM_TIMEOUT) begin
                e.strb = S_ABORT; waited = 0;
            end else begin
                e.strb = S_WAIT; m_sc++; waited++;
            end
        end else if (req && !ack) begin
            e.strb = S_WAIT; m_sc++; waited = 1;
        end else if (redir) begin
            e.strb = S_REDIR; m_fc++;
        end else if (lu) begin
            e.strb = S_LU; m_sc++; m_bc++;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [10:0] act;
            logic [95:0] cact;
            e    = exp_q.pop_front();
            act  = {hz.pc_stall, hz.pc_redirect, hz.if_stall, hz.if_clear, hz.id_stall,
                    hz.id_clear, hz.ex_stall, hz.ex_clear, hz.mem_stall, hz.mem_clear,
                    hz.mem_abort};
            cact = {hz.stall_cnt, hz.flush_cnt, hz.bubble_cnt};
            n_checks++;
            if (e.rst_cyc) begin
                if (hz.mem_abort === 1'b0) n_pass++;
                else $display("FAIL abort_in_reset t=%0t got=%b want=0", $time, hz.mem_abort);
            end else begin
                if (act === e.strb) n_pass++;
                else $display("FAIL strobes t=%0t got=%b want=%b", $time, act, e.strb);
                n_checks++;
                if (cact === e.cnts) n_pass++;
                else $display("FAIL counters t=%0t got=%h want=%h", $time, cact, e.cnts);
            end
        end
    end

    initial begin
        rst_n          = 1'b0;
        hz.id_rs_addr  = '0;
        hz.id_rt_addr  = '0;
        hz.id_use_rs   = 1'b0;
        hz.id_use_rt   = 1'b0;
        hz.ex_wr_addr  = '0;
        hz.ex_mem_rd   = 1'b0;
        hz.ex_redirect = 1'b0;
        hz.mem_req     = 1'b0;
        hz.mem_ack     = 1'b0;

        for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(INIT_CYCLES + 2);

        // Load-use on rs, then the same with the load writing r0, then rt through r0.
        step(1'b1, 5, 0, 1, 0, 5, 1, 0, 0, 0);
        idle(1);
        step(1'b1, 5, 0, 1, 0, 0, 1, 0, 0, 0);
        step(1'b1, 0, 0, 1, 1, 0, 1, 0, 0, 0);
        step(1'b1, 3, 7, 0, 1, 7, 1, 0, 0, 0);
        step(1'b1, 7, 3, 0, 1, 7, 1, 0, 0, 0);
        idle(1);

        // Redirect wins over a simultaneous load-use.
        step(1'b1, 5, 0, 1, 0, 5, 1, 1, 0, 0);
        idle(1);

        // Memory wait acked on the fourth request cycle.
        for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Ack with the first request: no stall.
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(1);

        // Timeout without ack, with a load-use and redirect held pending throughout.
        for (int i = 0; i < MEM_TIMEOUT + 1; i++) step(1'b1, 5, 0, 1, 0, 5, 1, 1, 1, 0);
        idle(2);

        // Request dropped mid-wait acts as ack.
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Reset in the middle of a wait.
        for (int i = 0; i < 3; i++) step(1'b1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1'b0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(INIT_CYCLES + 2);

        for (int i = 0; i < 3000; i++) begin
            logic r;
            logic q;
            r = ($urandom_range(299) != 0);
            q = (waited > 0) ? ($urandom_range(15) != 0) : ($urandom_range(5) == 0);
            step(r, 5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), q, ($urandom_range(4) == 0));
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
